// File: rtl/tx_intf_m_axis_trans_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// tx_intf_m_axis_trans_ctrl_pkg
//
// Shared definitions for the loopback transfer controller that sits between
// the tx_intf register slave and the m_axis master.
//
// Contents:
//   trans_state_t    controller FSM states
//   MODE_*           trigger-source selection codes for start_1trans_mode
//   DROP_CNT_WIDTH   width of the saturating dropped-beat counter
//   drop_cnt_inc     saturating increment used for the drop counter
// ---------------------------------------------------------------------------
package tx_intf_m_axis_trans_ctrl_pkg;

    // Controller states. IDLE must stay at zero so that a cleared state
    // register reads as "not busy".
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_START = 3'd2,
        ST_XFER  = 3'd3,
        ST_DONE  = 3'd4
    } trans_state_t;

    // Trigger source codes. Any mode with bit 1 set selects the external
    // trigger, so 2'b10 and 2'b11 behave identically.
    localparam logic [1:0] MODE_TX_END   = 2'b00;
    localparam logic [1:0] MODE_TX_START = 2'b01;
    localparam logic [1:0] MODE_EXT      = 2'b10;

    localparam int DROP_CNT_WIDTH = 8;

    localparam logic [DROP_CNT_WIDTH-1:0] DROP_CNT_MAX = '1;

    // True when the mode selects the external trigger input.
    function automatic logic is_ext_mode(input logic [1:0] mode);
        return mode[1];
    endfunction

    // Saturating increment: the counter sticks at its maximum value instead
    // of wrapping, so a long burst of drops never reads back as a small number.
    function automatic logic [DROP_CNT_WIDTH-1:0] drop_cnt_inc(
        input logic [DROP_CNT_WIDTH-1:0] cnt
    );
        if (cnt == DROP_CNT_MAX) begin
            return cnt;
        end
        return cnt + DROP_CNT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/tx_intf_m_axis_trans_ctrl_if.sv
// ---------------------------------------------------------------------------
// tx_intf_m_axis_trans_ctrl_if
//
// Bundle of the signals exchanged between the transfer controller and the
// m_axis master.
//
// Signals:
//   start_1trans_to_m_axis  controller -> m_axis  1-cycle start pulse
//   data_to_m_axis          controller -> m_axis  registered beat data
//   data_ready_to_m_axis    controller -> m_axis  registered beat valid
//   fulln_from_m_axis       m_axis -> controller  1 = FIFO can accept a beat
//
// Modports:
//   master  used by the transfer controller
//   slave   used by the m_axis side (or a testbench standing in for it)
// ---------------------------------------------------------------------------
interface tx_intf_m_axis_trans_ctrl_if #(
    parameter int DATA_WIDTH = 64
) ();

    logic                  start_1trans_to_m_axis;
    logic [DATA_WIDTH-1:0] data_to_m_axis;
    logic                  data_ready_to_m_axis;
    logic                  fulln_from_m_axis;

    modport master (
        output start_1trans_to_m_axis,
        output data_to_m_axis,
        output data_ready_to_m_axis,
        input  fulln_from_m_axis
    );

    modport slave (
        input  start_1trans_to_m_axis,
        input  data_to_m_axis,
        input  data_ready_to_m_axis,
        output fulln_from_m_axis
    );

endinterface

// File: rtl/tx_intf_m_axis_trans_ctrl_trig_sel.sv
// ---------------------------------------------------------------------------
// tx_intf_trig_sel
//
// Rising-edge detector for the transfer trigger. Each candidate source keeps
// its own one-cycle history register; the latched mode then picks which
// source's edge is reported.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   mode_q                    latched trigger mode (00 tx_end, 01 tx_start, 1x ext)
//   tx_end_from_acc           trigger source for mode 00
//   tx_start_from_acc         trigger source for mode 01
//   start_1trans_ext_trigger  trigger source for modes 10/11
//   trig_edge                 1 while the selected source is high and was low
//                             in the previous cycle
// ---------------------------------------------------------------------------
module tx_intf_trig_sel
    import tx_intf_m_axis_trans_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] mode_q,
    input  logic       tx_end_from_acc,
    input  logic       tx_start_from_acc,
    input  logic       start_1trans_ext_trigger,
    output logic       trig_edge
);

    logic tx_end_d1;
    logic tx_start_d1;
    logic ext_d1;

    // History is kept per source rather than after the mux. When a new arm
    // switches mode_q, the history of the newly selected source is already
    // valid, so a source that is high at arm time cannot fake an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_end_d1   <= 1'b0;
            tx_start_d1 <= 1'b0;
            ext_d1      <= 1'b0;
        end else begin
            tx_end_d1   <= tx_end_from_acc;
            tx_start_d1 <= tx_start_from_acc;
            ext_d1      <= start_1trans_ext_trigger;
        end
    end

    // Select the edge of the source chosen by the latched mode.
    always_comb begin
        trig_edge = 1'b0;
        if (is_ext_mode(mode_q)) begin
            trig_edge = start_1trans_ext_trigger & ~ext_d1;
        end else if (mode_q == MODE_TX_START) begin
            trig_edge = tx_start_from_acc & ~tx_start_d1;
        end else begin
            trig_edge = tx_end_from_acc & ~tx_end_d1;
        end
    end

endmodule

// File: rtl/tx_intf_m_axis_trans_ctrl.sv
// ---------------------------------------------------------------------------
// tx_intf_m_axis_trans_ctrl
//
// Sequences one loopback capture into m_axis per arm: latch the trigger mode
// and length, wait for a trigger edge, send a 1-cycle start pulse, forward up
// to trans_len accepted beats (with an optional inter-beat timeout), then
// report completion with a 1-cycle done pulse.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   arm                       1-cycle pulse: arm one transfer (ignored while busy
//                             or when trans_len is 0)
//   abort                     1-cycle pulse: abandon the current transfer
//   start_1trans_mode         trigger source select, latched on accepted arm
//   trans_len                 beats per transfer, latched on accepted arm
//   timeout_cycles            idle-cycle limit between beats; 0 disables it
//   tx_start_from_acc         trigger source, mode 01
//   tx_end_from_acc           trigger source, mode 00
//   start_1trans_ext_trigger  trigger source, modes 10/11
//   data_loopback             beat data
//   data_loopback_valid       beat valid
//   m_axis                    master side of the m_axis bundle (start pulse,
//                             registered data/ready, fulln back-pressure)
//   busy                      controller is not idle
//   done_pulse                1 cycle at transfer end (length or timeout)
//   timeout_flag              sticky: last transfer ended by timeout
//   beat_cnt                  beats accepted in the current/last transfer
//   drop_cnt                  beats dropped for lack of fulln, saturating
// ---------------------------------------------------------------------------
module tx_intf_m_axis_trans_ctrl
    import tx_intf_m_axis_trans_ctrl_pkg::*;
#(
    parameter int C_M00_AXIS_TDATA_WIDTH = 64,
    parameter int LEN_WIDTH              = 16,
    parameter int TMO_WIDTH              = 24
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              arm,
    input  logic                              abort,
    input  logic [1:0]                        start_1trans_mode,
    input  logic [LEN_WIDTH-1:0]              trans_len,
    input  logic [TMO_WIDTH-1:0]              timeout_cycles,
    input  logic                              tx_start_from_acc,
    input  logic                              tx_end_from_acc,
    input  logic                              start_1trans_ext_trigger,
    input  logic [C_M00_AXIS_TDATA_WIDTH-1:0] data_loopback,
    input  logic                              data_loopback_valid,
    tx_intf_m_axis_trans_ctrl_if.master       m_axis,
    output logic                              busy,
    output logic                              done_pulse,
    output logic                              timeout_flag,
    output logic [LEN_WIDTH-1:0]              beat_cnt,
    output logic [DROP_CNT_WIDTH-1:0]         drop_cnt
);

    trans_state_t state;
    trans_state_t state_nxt;

    logic [1:0]                        mode_q;
    logic [LEN_WIDTH-1:0]              len_q;
    logic [TMO_WIDTH-1:0]              idle_cnt;
    logic [TMO_WIDTH-1:0]              idle_inc;
    logic [LEN_WIDTH-1:0]              beat_cnt_q;
    logic [LEN_WIDTH-1:0]              beat_inc;
    logic [DROP_CNT_WIDTH-1:0]         drop_cnt_q;
    logic                              timeout_q;
    logic [C_M00_AXIS_TDATA_WIDTH-1:0] data_q;
    logic                              ready_q;

    logic trig_edge;
    logic arm_take;
    logic beat_acc;
    logic beat_drop;
    logic tmo_hit;

    tx_intf_trig_sel u_trig_sel (
        .clk                      (clk),
        .rst                      (rst),
        .mode_q                   (mode_q),
        .tx_end_from_acc          (tx_end_from_acc),
        .tx_start_from_acc        (tx_start_from_acc),
        .start_1trans_ext_trigger (start_1trans_ext_trigger),
        .trig_edge                (trig_edge)
    );

    assign idle_inc = idle_cnt + TMO_WIDTH'(1);
    assign beat_inc = beat_cnt_q + LEN_WIDTH'(1);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic plus the per-cycle event strobes used by the datapath.
    // abort is checked first so it overrides every other transition and also
    // suppresses beat acceptance and drop counting in the same cycle. In XFER
    // an accepted beat takes priority over the timeout: the timeout is only
    // evaluated on cycles with no accepted beat.
    always_comb begin
        state_nxt = state;
        arm_take  = 1'b0;
        beat_acc  = 1'b0;
        beat_drop = 1'b0;
        tmo_hit   = 1'b0;

        if (abort && (state != ST_IDLE)) begin
            state_nxt = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (arm && (trans_len != '0)) begin
                        arm_take  = 1'b1;
                        state_nxt = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (trig_edge) begin
                        state_nxt = ST_START;
                    end
                end
                ST_START: begin
                    state_nxt = ST_XFER;
                end
                ST_XFER: begin
                    if (data_loopback_valid && m_axis.fulln_from_m_axis) begin
                        beat_acc = 1'b1;
                        if (beat_inc == len_q) begin
                            state_nxt = ST_DONE;
                        end
                    end else begin
                        beat_drop = data_loopback_valid;
                        if ((timeout_cycles != '0) && (idle_inc == timeout_cycles)) begin
                            tmo_hit   = 1'b1;
                            state_nxt = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_nxt = ST_IDLE;
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Configuration latches, counters and the registered output beat.
    // The idle counter is held at zero outside XFER so it always starts from
    // zero on entry, and it restarts on every accepted beat. beat_cnt,
    // drop_cnt and timeout_flag only clear on an accepted arm so the results
    // of the last transfer stay readable afterwards (including after abort).
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q     <= '0;
            len_q      <= '0;
            idle_cnt   <= '0;
            beat_cnt_q <= '0;
            drop_cnt_q <= '0;
            timeout_q  <= 1'b0;
            data_q     <= '0;
            ready_q    <= 1'b0;
        end else begin
            if (arm_take) begin
                mode_q     <= start_1trans_mode;
                len_q      <= trans_len;
                beat_cnt_q <= '0;
                drop_cnt_q <= '0;
                timeout_q  <= 1'b0;
            end

            if (beat_acc) begin
                beat_cnt_q <= beat_inc;
            end

            if (beat_drop) begin
                drop_cnt_q <= drop_cnt_inc(drop_cnt_q);
            end

            if (tmo_hit) begin
                timeout_q <= 1'b1;
            end

            if ((state != ST_XFER) || beat_acc) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_inc;
            end

            ready_q <= beat_acc;
            if (beat_acc) begin
                data_q <= data_loopback;
            end
        end
    end

    // Status and strobe outputs decode directly from the state register.
    assign busy                          = (state != ST_IDLE);
    assign done_pulse                    = (state == ST_DONE);
    assign m_axis.start_1trans_to_m_axis = (state == ST_START);
    assign m_axis.data_to_m_axis         = data_q;
    assign m_axis.data_ready_to_m_axis   = ready_q;
    assign timeout_flag                  = timeout_q;
    assign beat_cnt                      = beat_cnt_q;
    assign drop_cnt                      = drop_cnt_q;

endmodule

// File: tb/tb_tx_intf_m_axis_trans_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tx_intf_m_axis_trans_ctrl
//
// Directed plus randomized stimulus for the loopback transfer controller.
// Beat-level expectations come from a transaction model that walks the
// stimulus list using the transfer rules (accept, drop, idle timeout, length).
// ---------------------------------------------------------------------------
module tb_tx_intf_m_axis_trans_ctrl;

    localparam int W   = 64;
    localparam int LEN = 16;
    localparam int TMO = 24;

    logic           clk = 1'b0;
    logic           rst;
    logic           arm;
    logic           abort;
    logic [1:0]     mode;
    logic [LEN-1:0] trans_len;
    logic [TMO-1:0] tmo;
    logic           tx_start;
    logic           tx_end;
    logic           ext_trig;
    logic [W-1:0]   din;
    logic           dvalid;
    logic           busy;
    logic           done_pulse;
    logic           timeout_flag;
    logic [LEN-1:0] beat_cnt;
    logic [7:0]     drop_cnt;

    int total = 0;
    int bad   = 0;

    // Stimulus list for one XFER phase: valid, fulln, data per cycle.
    bit           sv[$];
    bit           sf[$];
    logic [W-1:0] sd[$];

    tx_intf_m_axis_trans_ctrl_if #(.DATA_WIDTH(W)) m_axis ();

    tx_intf_m_axis_trans_ctrl #(
        .C_M00_AXIS_TDATA_WIDTH (W),
        .LEN_WIDTH              (LEN),
        .TMO_WIDTH              (TMO)
    ) dut (
        .clk                      (clk),
        .rst                      (rst),
        .arm                      (arm),
        .abort                    (abort),
        .start_1trans_mode        (mode),
        .trans_len                (trans_len),
        .timeout_cycles           (tmo),
        .tx_start_from_acc        (tx_start),
        .tx_end_from_acc          (tx_end),
        .start_1trans_ext_trigger (ext_trig),
        .data_loopback            (din),
        .data_loopback_valid      (dvalid),
        .m_axis                   (m_axis),
        .busy                     (busy),
        .done_pulse               (done_pulse),
        .timeout_flag             (timeout_flag),
        .beat_cnt                 (beat_cnt),
        .drop_cnt                 (drop_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit v, input bit f, input logic [W-1:0] d);
        dvalid                   = v;
        m_axis.fulln_from_m_axis = f;
        din                      = d;
        tick();
    endtask

    function automatic logic [W-1:0] rnd_data();
        return {$urandom, $urandom};
    endfunction

    task automatic pushBeat(input bit v, input bit f);
        sv.push_back(v);
        sf.push_back(f);
        sd.push_back(rnd_data());
    endtask

    task automatic armXfer(input logic [1:0] m, input int len, input int t, input string tag);
        mode      = m;
        trans_len = LEN'(len);
        tmo       = TMO'(t);
        arm       = 1'b1;
        tick();
        arm = 1'b0;
        checkOutput({tag, "_arm_busy"}, busy, 1'b1);
        checkOutput({tag, "_arm_tflag"}, timeout_flag, 1'b0);
        checkOutput({tag, "_arm_bcnt"}, beat_cnt, 0);
    endtask

    // Raise the source for mode m for one cycle and expect exactly one start pulse.
    task automatic fireTrigger(input logic [1:0] m, input string tag);
        if (m[1]) ext_trig = 1'b1;
        else if (m == 2'b01) tx_start = 1'b1;
        else tx_end = 1'b1;
        tick();
        checkOutput({tag, "_start"}, m_axis.start_1trans_to_m_axis, 1'b1);
        tx_start = 1'b0;
        tx_end   = 1'b0;
        ext_trig = 1'b0;
        tick();
        checkOutput({tag, "_start_end"}, m_axis.start_1trans_to_m_axis, 1'b0);
        checkOutput({tag, "_xfer_busy"}, busy, 1'b1);
    endtask

    // Transaction model over the stimulus list, then drive it and compare
    // beat by beat. cnt0/drops0/idle0 continue a transfer already in progress.
    task automatic runXfer(input int len, input int t, input int cnt0, input int drops0,
                           input int idle0, input string tag,
                           output bit ended, output int cnt_o, output int drops_o, output int idle_o);
        int cnt;
        int drops;
        int idle;
        int end_i;
        bit to;
        bit exp_acc[$];
        cnt   = cnt0;
        drops = drops0;
        idle  = idle0;
        end_i = -1;
        to    = 1'b0;
        for (int i = 0; i < sv.size(); i++) begin
            if (end_i >= 0) break;
            exp_acc.push_back(sv[i] && sf[i]);
            if (sv[i] && sf[i]) begin
                cnt++;
                idle = 0;
                if (cnt == len) end_i = i;
            end else begin
                if (sv[i] && drops < 255) drops++;
                idle++;
                if (t != 0 && idle == t) begin
                    end_i = i;
                    to    = 1'b1;
                end
            end
        end
        for (int i = 0; i < exp_acc.size(); i++) begin
            applyStimulus(sv[i], sf[i], sd[i]);
            checkOutput({tag, "_rdy"}, m_axis.data_ready_to_m_axis, exp_acc[i]);
            if (exp_acc[i]) checkOutput({tag, "_data"}, m_axis.data_to_m_axis, sd[i]);
            checkOutput({tag, "_done"}, done_pulse, (i == end_i));
        end
        dvalid = 1'b0;
        ended  = (end_i >= 0);
        if (ended) begin
            tick();
            checkOutput({tag, "_idle_busy"}, busy, 1'b0);
            checkOutput({tag, "_idle_done"}, done_pulse, 1'b0);
        end else begin
            checkOutput({tag, "_still_busy"}, busy, 1'b1);
        end
        checkOutput({tag, "_bcnt"}, beat_cnt, cnt);
        checkOutput({tag, "_dcnt"}, drop_cnt, drops);
        checkOutput({tag, "_tflag"}, timeout_flag, to);
        cnt_o   = cnt;
        drops_o = drops;
        idle_o  = idle;
        sv.delete();
        sf.delete();
        sd.delete();
    endtask

    task automatic doAbort(input string tag);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput({tag, "_abort_busy"}, busy, 1'b0);
        checkOutput({tag, "_abort_done"}, done_pulse, 1'b0);
    endtask

    initial begin
        bit          ended;
        int          cnt;
        int          drops;
        int          idle;
        logic [1:0]  m;
        int          len;
        int          t;

        rst       = 1'b1;
        arm       = 1'b0;
        abort     = 1'b0;
        mode      = 2'b00;
        trans_len = '0;
        tmo       = '0;
        tx_start  = 1'b0;
        tx_end    = 1'b0;
        ext_trig  = 1'b0;
        din       = '0;
        dvalid    = 1'b0;
        m_axis.fulln_from_m_axis = 1'b0;
        tick();
        tick();

        // Reset state
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done_pulse, 1'b0);
        checkOutput("rst_start", m_axis.start_1trans_to_m_axis, 1'b0);
        checkOutput("rst_rdy", m_axis.data_ready_to_m_axis, 1'b0);
        checkOutput("rst_data", m_axis.data_to_m_axis, 0);
        checkOutput("rst_bcnt", beat_cnt, 0);
        checkOutput("rst_dcnt", drop_cnt, 0);
        checkOutput("rst_tflag", timeout_flag, 1'b0);
        rst = 1'b0;
        tick();

        // 1: mode 00, tx_end pulse 5 cycles after arm, 4 clean beats
        armXfer(2'b00, 4, 0, "s1");
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("s1_wait_start", m_axis.start_1trans_to_m_axis, 1'b0);
        end
        fireTrigger(2'b00, "s1");
        for (int i = 0; i < 4; i++) pushBeat(1'b1, 1'b1);
        runXfer(4, 0, 0, 0, 0, "s1", ended, cnt, drops, idle);
        checkOutput("s1_ended", ended, 1'b1);

        // 2: mode 01 with tx_start already high at arm; other sources ignored
        tx_start = 1'b1;
        tick();
        armXfer(2'b01, 2, 0, "s2");
        tx_end = 1'b1;
        tick();
        checkOutput("s2_no_start_a", m_axis.start_1trans_to_m_axis, 1'b0);
        tx_end   = 1'b0;
        ext_trig = 1'b1;
        tick();
        checkOutput("s2_no_start_b", m_axis.start_1trans_to_m_axis, 1'b0);
        ext_trig = 1'b0;
        tx_start = 1'b0;
        tick();
        checkOutput("s2_no_start_c", m_axis.start_1trans_to_m_axis, 1'b0);
        checkOutput("s2_armed_busy", busy, 1'b1);
        fireTrigger(2'b01, "s2");
        pushBeat(1'b1, 1'b1);
        pushBeat(1'b1, 1'b1);
        runXfer(2, 0, 0, 0, 0, "s2", ended, cnt, drops, idle);

        // 3: len 8, back-pressure on beats 3 and 4
        armXfer(2'b10, 8, 0, "s3");
        fireTrigger(2'b10, "s3");
        for (int i = 0; i < 8; i++) pushBeat(1'b1, !(i == 2 || i == 3));
        runXfer(8, 0, 0, 0, 0, "s3a", ended, cnt, drops, idle);
        checkOutput("s3_mid_bcnt", beat_cnt, 6);
        checkOutput("s3_mid_dcnt", drop_cnt, 2);
        pushBeat(1'b1, 1'b1);
        pushBeat(1'b1, 1'b1);
        runXfer(8, 0, cnt, drops, idle, "s3b", ended, cnt, drops, idle);
        checkOutput("s3_final_bcnt", beat_cnt, 8);

        // 4: timeout 10 after two beats
        armXfer(2'b11, 4, 10, "s4");
        fireTrigger(2'b11, "s4");
        pushBeat(1'b1, 1'b1);
        pushBeat(1'b1, 1'b1);
        for (int i = 0; i < 12; i++) pushBeat(1'b0, 1'b1);
        runXfer(4, 10, 0, 0, 0, "s4", ended, cnt, drops, idle);
        checkOutput("s4_tflag", timeout_flag, 1'b1);
        checkOutput("s4_bcnt", beat_cnt, 2);

        // 5: next arm clears the flag; abort in XFER after one beat
        armXfer(2'b00, 3, 0, "s5");
        fireTrigger(2'b00, "s5");
        pushBeat(1'b1, 1'b1);
        runXfer(3, 0, 0, 0, 0, "s5", ended, cnt, drops, idle);
        doAbort("s5");
        checkOutput("s5_hold_bcnt", beat_cnt, 1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, rnd_data());
            checkOutput("s5_no_rdy", m_axis.data_ready_to_m_axis, 1'b0);
            checkOutput("s5_no_done", done_pulse, 1'b0);
        end
        dvalid = 1'b0;

        // 6a: arm with length 0 is ignored
        trans_len = '0;
        arm       = 1'b1;
        tick();
        arm = 1'b0;
        checkOutput("s6_len0_idle", busy, 1'b0);

        // 6b: arm and trigger edge in the same cycle
        mode      = 2'b00;
        trans_len = LEN'(2);
        tx_end    = 1'b1;
        arm       = 1'b1;
        tick();
        arm = 1'b0;
        checkOutput("s6_same_busy", busy, 1'b1);
        tick();
        checkOutput("s6_same_no_start", m_axis.start_1trans_to_m_axis, 1'b0);
        tx_end = 1'b0;
        tick();
        checkOutput("s6_same_no_start2", m_axis.start_1trans_to_m_axis, 1'b0);
        doAbort("s6b");
        tx_end = 1'b1;
        tick();
        tx_end = 1'b0;
        checkOutput("s6_idle_edge", m_axis.start_1trans_to_m_axis, 1'b0);
        tick();
        checkOutput("s6_idle_edge_busy", busy, 1'b0);

        // 6c: arm while busy is ignored, including mode/length changes
        armXfer(2'b00, 3, 0, "s6c");
        mode      = 2'b10;
        trans_len = LEN'(5);
        arm       = 1'b1;
        tick();
        arm = 1'b0;
        ext_trig = 1'b1;
        tick();
        ext_trig = 1'b0;
        checkOutput("s6c_ext_ignored", m_axis.start_1trans_to_m_axis, 1'b0);
        fireTrigger(2'b00, "s6c");
        for (int i = 0; i < 3; i++) pushBeat(1'b1, 1'b1);
        runXfer(3, 0, 0, 0, 0, "s6c", ended, cnt, drops, idle);

        // 6d: reset in XFER discards a pending beat
        armXfer(2'b01, 4, 0, "s6d");
        fireTrigger(2'b01, "s6d");
        dvalid = 1'b1;
        m_axis.fulln_from_m_axis = 1'b1;
        din = rnd_data();
        rst = 1'b1;
        tick();
        dvalid = 1'b0;
        checkOutput("s6d_busy", busy, 1'b0);
        checkOutput("s6d_rdy", m_axis.data_ready_to_m_axis, 1'b0);
        checkOutput("s6d_data", m_axis.data_to_m_axis, 0);
        checkOutput("s6d_bcnt", beat_cnt, 0);
        checkOutput("s6d_start", m_axis.start_1trans_to_m_axis, 1'b0);
        rst = 1'b0;
        tick();

        // Drop counter saturation, then a single beat finishes len 1
        armXfer(2'b00, 1, 0, "sat");
        fireTrigger(2'b00, "sat");
        for (int i = 0; i < 300; i++) pushBeat(1'b1, 1'b0);
        runXfer(1, 0, 0, 0, 0, "sat_a", ended, cnt, drops, idle);
        checkOutput("sat_dcnt", drop_cnt, 255);
        pushBeat(1'b1, 1'b1);
        runXfer(1, 0, cnt, drops, idle, "sat_b", ended, cnt, drops, idle);

        // Randomized transfers
        for (int r = 0; r < 10; r++) begin
            m   = 2'($urandom_range(0, 3));
            len = $urandom_range(1, 6);
            t   = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(2, 6);
            armXfer(m, len, t, "rnd");
            for (int k = $urandom_range(0, 3); k > 0; k--) tick();
            fireTrigger(m, "rnd");
            for (int i = 0; i < 20; i++)
                pushBeat($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 75);
            runXfer(len, t, 0, 0, 0, "rnd", ended, cnt, drops, idle);
            if (!ended) doAbort("rnd");
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
